// File: rtl/neuron_p_pkg.sv
// Shared definitions for the neuron_p output neuron: default word format,
// PLAN sigmoid breakpoints/offsets (scaled by FRAC) and the FSM state encoding.
package neuron_p_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_BIAS = 3'd2,
    ST_ACT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // PLAN constants in Q.FRAC; FRAC >= 5 keeps every shift non-negative
  function automatic int plan_one(input int frac);
    return 32'sd1 <<< frac;
  endfunction

  function automatic int plan_b2375(input int frac);
    return 32'sd19 <<< (frac - 32'sd3);
  endfunction

  function automatic int plan_five(input int frac);
    return 32'sd5 <<< frac;
  endfunction

  function automatic int plan_c084375(input int frac);
    return 32'sd27 <<< (frac - 32'sd5);
  endfunction

  function automatic int plan_c0625(input int frac);
    return 32'sd5 <<< (frac - 32'sd3);
  endfunction

  function automatic int plan_half(input int frac);
    return 32'sd1 <<< (frac - 32'sd1);
  endfunction

endpackage

// File: rtl/neuron_p_sig_plan.sv
// Combinational shift-only piecewise-linear sigmoid (PLAN) on a signed
// Q(WIDTH-FRAC).FRAC word; output lies in 0..1.0.
module sig_plan
  import neuron_p_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(plan_one(FRAC));
  localparam logic [WIDTH-1:0] B2375   = WIDTH'(plan_b2375(FRAC));
  localparam logic [WIDTH-1:0] FIVE    = WIDTH'(plan_five(FRAC));
  localparam logic [WIDTH-1:0] C084375 = WIDTH'(plan_c084375(FRAC));
  localparam logic [WIDTH-1:0] C0625   = WIDTH'(plan_c0625(FRAC));
  localparam logic [WIDTH-1:0] HALF    = WIDTH'(plan_half(FRAC));
  localparam logic [WIDTH-1:0] LSB     = WIDTH'(1'b1);

  logic [WIDTH-1:0] mag_s;
  logic [WIDTH-1:0] pos_s;

  // Magnitude is treated as unsigned so the most-negative z lands in the top region
  always_comb begin
    mag_s = '0;
    pos_s = '0;
    y     = '0;
    if (z[WIDTH-1]) begin
      mag_s = ~z + LSB;
    end else begin
      mag_s = z;
    end
    if (mag_s >= FIVE) begin
      pos_s = ONE;
    end else if (mag_s >= B2375) begin
      pos_s = (mag_s >> 3'd5) + C084375;
    end else if (mag_s >= ONE) begin
      pos_s = (mag_s >> 2'd3) + C0625;
    end else begin
      pos_s = (mag_s >> 2'd2) + HALF;
    end
    if (z[WIDTH-1]) begin
      y = ONE - pos_s;
    end else begin
      y = pos_s;
    end
  end

endmodule

// File: rtl/neuron_p.sv
// Parametrised output neuron: serial MAC over N_IN pairs, bias add, PLAN sigmoid.
// Define NEURON_P_SAT_EN to clamp the rescaled sum instead of wrapping it.
module neuron_p
  import neuron_p_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ACC_W = 2*WIDTH + $clog2(N_IN) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_rdy,
  input  logic [N_IN*WIDTH-1:0]   data_i,
  input  logic [N_IN*WIDTH-1:0]   data_w,
  input  logic [WIDTH-1:0]        bias,
  output logic                    busy,
  output logic [WIDTH-1:0]        neu_out,
  output logic                    neu_rdy
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  state_t                  state_r;
  logic                    in_rdy_q_r;
  logic [WIDTH-1:0]        x_r [N_IN];
  logic [WIDTH-1:0]        w_r [N_IN];
  logic [WIDTH-1:0]        bias_r;
  logic [WIDTH-1:0]        z_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [IDX_W-1:0]        idx_r;

  logic                      start_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic [WIDTH-1:0]          z_next_s;
  logic [WIDTH-1:0]          y_s;

  assign start_s = in_rdy & ~in_rdy_q_r;

  // Operands are sign-extended to full product width so the 2W-bit result is exact
  assign prod_s = $signed({{WIDTH{x_r[idx_r][WIDTH-1]}}, x_r[idx_r]})
                * $signed({{WIDTH{w_r[idx_r][WIDTH-1]}}, w_r[idx_r]});

  assign sum_s = acc_r + ($signed({{(ACC_W-WIDTH){bias_r[WIDTH-1]}}, bias_r}) <<< FRAC);

`ifdef NEURON_P_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted_s;
  assign shifted_s = sum_s >>> FRAC;

  // Clamp the floor-rescaled sum into the signed WIDTH range
  always_comb begin
    z_next_s = '0;
    if (shifted_s > SAT_MAX) begin
      z_next_s = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shifted_s < SAT_MIN) begin
      z_next_s = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      z_next_s = shifted_s[WIDTH-1:0];
    end
  end
`else
  assign z_next_s = WIDTH'(sum_s >>> FRAC);
`endif

  sig_plan #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_plan (
    .z (z_r),
    .y (y_s)
  );

  // Control FSM, operand capture, serial accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      in_rdy_q_r <= 1'b0;
      acc_r      <= '0;
      idx_r      <= '0;
      z_r        <= '0;
      busy       <= 1'b0;
      neu_out    <= '0;
      neu_rdy    <= 1'b0;
    end else begin
      in_rdy_q_r <= in_rdy;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            for (int k = 0; k < N_IN; k++) begin
              x_r[k] <= data_i[k*WIDTH +: WIDTH];
              w_r[k] <= data_w[k*WIDTH +: WIDTH];
            end
            bias_r  <= bias;
            acc_r   <= '0;
            idx_r   <= '0;
            busy    <= 1'b1;
            neu_rdy <= 1'b0;
            state_r <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_r <= acc_r + {{(ACC_W-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
          if (idx_r == IDX_LAST) begin
            state_r <= ST_BIAS;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_BIAS: begin
          z_r     <= z_next_s;
          state_r <= ST_ACT;
        end
        ST_ACT: begin
          neu_out <= y_s;
          neu_rdy <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_p.sv
// Self-checking bench for neuron_p (N_IN=8, WIDTH=16, FRAC=8): directed literal
// cases plus randomized runs checked every cycle against a behavioural model.
module tb_neuron_p;

  localparam int N = 8;
  localparam int W = 16;
  localparam int LAT = N + 2;

  logic           clk;
  logic           reset;
  logic           in_rdy;
  logic [N*W-1:0] data_i;
  logic [N*W-1:0] data_w;
  logic [W-1:0]   bias;
  logic           busy;
  logic [W-1:0]   neu_out;
  logic           neu_rdy;

  int total = 0;
  int bad   = 0;

  neuron_p dut (
    .clk     (clk),
    .reset   (reset),
    .in_rdy  (in_rdy),
    .data_i  (data_i),
    .data_w  (data_w),
    .bias    (bias),
    .busy    (busy),
    .neu_out (neu_out),
    .neu_rdy (neu_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected sigmoid output straight from the arithmetic definition
  function automatic logic [15:0] golden(input logic [N*W-1:0] di, input logic [N*W-1:0] dw,
                                         input logic [W-1:0] b);
    longint s;
    longint z;
    int     a;
    int     y;
    logic [63:0] zbits;
    s = longint'($signed(b)) * 256;
    for (int k = 0; k < N; k++)
      s += longint'($signed(di[k*W +: W])) * longint'($signed(dw[k*W +: W]));
    z = s >>> 8;
`ifdef NEURON_P_SAT_EN
    if (z > 32767) z = 32767;
    else if (z < -32768) z = -32768;
`else
    zbits = z;
    z = longint'($signed(zbits[15:0]));
`endif
    a = (z < 0) ? int'(-z) : int'(z);
    if (a >= 1280)      y = 256;
    else if (a >= 608)  y = a / 32 + 216;
    else if (a >= 256)  y = a / 8 + 160;
    else                y = a / 4 + 128;
    if (z < 0) y = 256 - y;
    return 16'(y);
  endfunction

  // Cycle-level behavioural model: one result LAT edges after an accepted rising start
  bit          m_live  = 1'b0;
  bit          m_busy, m_rdy, m_known, m_prev;
  int          m_cnt;
  logic [15:0] m_out, m_res;

  always @(posedge clk) begin
    if (reset) begin
      m_live  <= 1'b1;
      m_busy  <= 1'b0;
      m_rdy   <= 1'b0;
      m_out   <= 16'h0000;
      m_known <= 1'b1;
      m_cnt   <= 0;
      m_prev  <= 1'b0;
    end else begin
      m_prev <= in_rdy;
      if (in_rdy && !m_prev && m_cnt == 0) begin
        m_res   <= golden(data_i, data_w, bias);
        m_cnt   <= LAT;
        m_busy  <= 1'b1;
        m_rdy   <= 1'b0;
        m_known <= 1'b0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_cnt   <= 0;
        m_busy  <= 1'b0;
        m_rdy   <= 1'b1;
        m_out   <= m_res;
        m_known <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("busy", busy, m_busy);
      check("neu_rdy", neu_rdy, m_rdy);
      if (m_known) check("neu_out", neu_out, m_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_all(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
    for (int k = 0; k < N; k++) begin
      data_i[k*W +: W] = x;
      data_w[k*W +: W] = w;
    end
    bias = b;
  endtask

  task automatic set_one(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
    set_all(16'h0000, 16'h0000, b);
    data_i[15:0] = x;
    data_w[15:0] = w;
  endtask

  // Wait (bounded) for neu_rdy; returns the number of edges waited
  task automatic wait_rdy(output int n);
    n = 0;
    while (!neu_rdy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string name, input logic [15:0] expv, input bit keep_high);
    int n;
    in_rdy = 1'b0;
    tick();
    in_rdy = 1'b1;
    tick();
    wait_rdy(n);
    check({name, "_latency"}, n, LAT);
    check(name, neu_out, expv);
    if (!keep_high) in_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b1;
    in_rdy = 1'b0;
    set_all(16'h0000, 16'h0000, 16'h0000);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("reset_out", neu_out, 16'h0000);
    check("reset_rdy", neu_rdy, 1'b0);
    check("reset_busy", busy, 1'b0);

    check("model_zero", golden('0, '0, 16'h0000), 16'h0080);
    set_one(16'h0100, 16'hFE00, 16'h0000);
    check("model_neg2", golden(data_i, data_w, bias), 16'h0020);

    set_all(16'h0000, 16'h0000, 16'h0000);
    run("all_zero", 16'h0080, 1'b1);
    repeat (3) tick();
    check("hold_out", neu_out, 16'h0080);
    check("hold_rdy", neu_rdy, 1'b1);
    in_rdy = 1'b0;

    set_all(16'h0100, 16'h0100, 16'h0000);
    run("sat_pos", 16'h0100, 1'b0);
    set_all(16'h0100, 16'hFF00, 16'h0000);
    run("sat_neg", 16'h0000, 1'b0);
    set_one(16'h0100, 16'h0100, 16'h0000);
    run("one", 16'h00C0, 1'b0);
    set_one(16'h0100, 16'h0100, 16'hFF00);
    run("bias_cancel", 16'h0080, 1'b0);
    set_one(16'h0100, 16'hFE00, 16'h0000);
    run("neg_two", 16'h0020, 1'b0);
    set_one(16'h0300, 16'h0100, 16'h0000);
    run("three", 16'h00F0, 1'b0);

    // Start edge mid-MAC and input changes after capture must both be ignored
    set_one(16'h0100, 16'h0100, 16'h0000);
    in_rdy = 1'b0;
    tick();
    in_rdy = 1'b1;
    tick();
    repeat (2) tick();
    in_rdy = 1'b0;
    set_all(16'h0000, 16'h0000, 16'h0000);
    tick();
    in_rdy = 1'b1;
    tick();
    wait_rdy(n);
    check("ignored_start", neu_out, 16'h00C0);
    check("ignored_start_rdy", neu_rdy, 1'b1);

    // Reset in the middle of MAC with in_rdy held high restarts right after release
    set_all(16'h0100, 16'h0100, 16'h0000);
    in_rdy = 1'b0;
    tick();
    in_rdy = 1'b1;
    tick();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midreset_out", neu_out, 16'h0000);
    check("midreset_rdy", neu_rdy, 1'b0);
    check("midreset_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check("restart_busy", busy, 1'b1);
    wait_rdy(n);
    check("restart_latency", n, LAT);
    check("restart_out", neu_out, 16'h0100);

    set_all(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run("max_inputs", 16'h0100, 1'b0);

    // Randomized runs, some with a spurious start toggle during the compute
    for (int r = 0; r < 60; r++) begin
      for (int k = 0; k < N; k++) begin
        if (r % 3 == 0) begin
          data_i[k*W +: W] = 16'($urandom);
          data_w[k*W +: W] = 16'($urandom);
        end else begin
          data_i[k*W +: W] = 16'($urandom_range(0, 1023) - 512);
          data_w[k*W +: W] = 16'($urandom_range(0, 1023) - 512);
        end
      end
      bias = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
      in_rdy = 1'b0;
      tick();
      in_rdy = 1'b1;
      tick();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) tick();
        in_rdy = 1'b0;
        data_i = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_rdy = 1'b1;
      end
      wait_rdy(n);
      check("random_done", neu_rdy, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    in_rdy = 1'b0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
